tx_source: RTL and testbench



---
 rtl/tx_source_pkg.sv | 36 +++
 rtl/tx_skid_fifo.sv | 57 +++++
 rtl/tx_source.sv | 180 ++++++++++++++++++
 tb/tb_tx_source.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_source_pkg.sv
// tx_source_pkg: shared state encodings, word field positions and error width
// for the upstream transmitter that feeds the two-VC switch fabric.
`default_nettype none

package tx_source_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_INIT      = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_SEND      = 3'd3,
        ST_HOLD      = 3'd4,
        ST_ERROR     = 3'd5
    } tx_state_e;

    localparam int WORD_W      = 6;
    localparam int VC_BIT      = 5;
    localparam int DEST_BIT    = 4;
    localparam int PAYLOAD_MSB = 3;
    localparam int ERR_W       = 5;

    function automatic logic word_vc(input logic [WORD_W-1:0] w);
        return w[VC_BIT];
    endfunction

    function automatic logic word_dest(input logic [WORD_W-1:0] w);
        return w[DEST_BIT];
    endfunction

    function automatic logic [PAYLOAD_MSB:0] word_payload(input logic [WORD_W-1:0] w);
        return w[PAYLOAD_MSB:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_skid_fifo.sv
// tx_skid_fifo: synchronous DEPTH x 6 host-side buffer with push, pop, flush
// and occupancy count; head is presented combinationally from the read pointer.
`default_nettype none

module tx_skid_fifo
    import tx_source_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WORD_W-1:0]       din,
    output logic [WORD_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/tx_source.sv
// tx_source: init/threshold programming sequencer and paced word pusher into the
// switch main FIFO. Optional per-VC push counters are enabled by TX_STATS_EN.
`default_nettype none

module tx_source
    import tx_source_pkg::*;
#(
    parameter int         BUF_DEPTH   = 4,
    parameter int         INIT_CYCLES = 2,
    parameter logic [1:0] AF_MF_CFG   = 2'd2,
    parameter logic [1:0] AE_MF_CFG   = 2'd1,
    parameter logic [3:0] AF_VC_CFG   = 4'd12,
    parameter logic [3:0] AE_VC_CFG   = 4'd2,
    parameter logic [1:0] AF_D_CFG    = 2'd3,
    parameter logic [1:0] AE_D_CFG    = 2'd1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    input  logic [WORD_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              pause,
    input  logic              idle,
    input  logic [ERR_W-1:0]  error,
    output logic              init,
    output logic [1:0]        afMF,
    output logic [1:0]        aeMF,
    output logic [3:0]        afVC,
    output logic [3:0]        aeVC,
    output logic [1:0]        afDF,
    output logic [1:0]        aeDF,
    output logic [WORD_W-1:0] data_in,
    output logic              push_main,
    output logic [2:0]        tx_state,
    output logic              tx_error
`ifdef TX_STATS_EN
    ,
    output logic [7:0]        words_vc0,
    output logic [7:0]        words_vc1
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int ICW   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [ICW-1:0]   INIT_LAST = ICW'(INIT_CYCLES - 1);

    tx_state_e         state, state_nx;
    logic [ICW-1:0]    init_cnt, init_cnt_nx;
    logic              init_nx, push_nx, err_nx;
    logic [WORD_W-1:0] data_nx, head;
    logic [CNT_W-1:0]  count;
    logic              pop, flush, enter_init, host_push, err_any, can_fault;

    assign err_any    = |error;
    assign host_ready = (count < FULL_CNT) && (state != ST_RESET) && (state != ST_ERROR);
    assign host_push  = host_valid && host_ready;
    assign can_fault  = (state == ST_INIT) || (state == ST_WAIT_IDLE) ||
                        (state == ST_SEND) || (state == ST_HOLD);
    assign tx_state   = state;

    tx_skid_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (host_push),
        .pop     (pop),
        .flush   (flush),
        .din     (host_data),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_RESET;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        init_nx     = 1'b0;
        push_nx     = 1'b0;
        data_nx     = data_in;
        err_nx      = tx_error;
        pop         = 1'b0;
        flush       = 1'b0;
        enter_init  = 1'b0;
        case (state)
            ST_RESET:     if (start) enter_init = 1'b1;
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nx = ST_WAIT_IDLE;
                end else begin
                    init_nx     = 1'b1;
                    init_cnt_nx = init_cnt + 1'b1;
                end
            end
            ST_WAIT_IDLE: if (idle) state_nx = ST_SEND;
            ST_SEND: begin
                if (pause) begin
                    state_nx = ST_HOLD;
                end else if (count != '0) begin
                    pop     = 1'b1;
                    push_nx = 1'b1;
                    data_nx = head;
                end
            end
            ST_HOLD:      if (!pause) state_nx = ST_SEND;
            ST_ERROR:     if (start && !err_any) enter_init = 1'b1;
            default:      state_nx = ST_RESET;
        endcase
        if (enter_init) begin
            state_nx    = ST_INIT;
            init_nx     = 1'b1;
            init_cnt_nx = '0;
        end
        // A switch error overrides everything, including a pop already chosen.
        if (err_any && can_fault) begin
            state_nx = ST_ERROR;
            flush    = 1'b1;
            pop      = 1'b0;
            push_nx  = 1'b0;
            data_nx  = data_in;
            init_nx  = 1'b0;
            err_nx   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            init_cnt  <= '0;
            init      <= 1'b0;
            push_main <= 1'b0;
            data_in   <= '0;
            tx_error  <= 1'b0;
            afMF      <= '0;
            aeMF      <= '0;
            afVC      <= '0;
            aeVC      <= '0;
            afDF      <= '0;
            aeDF      <= '0;
        end else begin
            init_cnt  <= init_cnt_nx;
            init      <= init_nx;
            push_main <= push_nx;
            data_in   <= data_nx;
            tx_error  <= err_nx;
            if (enter_init) begin
                afMF <= AF_MF_CFG;
                aeMF <= AE_MF_CFG;
                afVC <= AF_VC_CFG;
                aeVC <= AE_VC_CFG;
                afDF <= AF_D_CFG;
                aeDF <= AE_D_CFG;
            end
        end
    end

`ifdef TX_STATS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            words_vc0 <= '0;
            words_vc1 <= '0;
        end else if (enter_init) begin
            words_vc0 <= '0;
            words_vc1 <= '0;
        end else if (push_nx) begin
            if (word_vc(head)) begin
                if (words_vc1 != 8'hFF) words_vc1 <= words_vc1 + 1'b1;
            end else begin
                if (words_vc0 != 8'hFF) words_vc0 <= words_vc0 + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_source.sv
// tb_tx_source: table vectors, directed corner sequences and randomized traffic
// checked against a queue-based behavioural model of the transmitter.
`default_nettype none

module tb_tx_source;

    localparam int DEPTH = 4;
    localparam int ICYC  = 2;
    localparam logic [15:0] THR = {2'd2, 2'd1, 4'd12, 4'd2, 2'd3, 2'd1};

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       start = 1'b0, host_valid = 1'b0, pause = 1'b0, idle = 1'b0;
    logic [5:0] host_data = '0;
    logic [4:0] error = '0;
    logic       host_ready, init, push_main, tx_error;
    logic [1:0] afMF, aeMF, afDF, aeDF;
    logic [3:0] afVC, aeVC;
    logic [5:0] data_in;
    logic [2:0] tx_state;
`ifdef TX_STATS_EN
    logic [7:0] words_vc0, words_vc1;
`endif

    always #5 clk = ~clk;

    tx_source dut (
        .clk(clk), .reset_L(reset_L), .start(start), .host_data(host_data),
        .host_valid(host_valid), .host_ready(host_ready), .pause(pause), .idle(idle),
        .error(error), .init(init), .afMF(afMF), .aeMF(aeMF), .afVC(afVC), .aeVC(aeVC),
        .afDF(afDF), .aeDF(aeDF), .data_in(data_in), .push_main(push_main),
        .tx_state(tx_state), .tx_error(tx_error)
`ifdef TX_STATS_EN
        , .words_vc0(words_vc0), .words_vc1(words_vc1)
`endif
    );

    int ncmp = 0, nfail = 0;

    // Behavioural model: mode follows the published state numbering; buffer is a queue.
    int         ms, ileft, mvc0, mvc1;
    logic [5:0] mq[$];
    bit         mpush, merr, mcfg;
    logic [5:0] mdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; ileft = 0; mq.delete(); mpush = 0; mdata = '0;
        merr = 0; mcfg = 0; mvc0 = 0; mvc1 = 0;
    endtask

    function automatic bit model_ready();
        return (mq.size() < DEPTH) && (ms != 0) && (ms != 5);
    endfunction

    task automatic model_enter_init();
        ms = 1; ileft = ICYC; mcfg = 1; mvc0 = 0; mvc1 = 0;
    endtask

    task automatic model_edge(input bit st, input bit hv, input logic [5:0] hd,
                              input bit pz, input bit idl, input logic [4:0] er,
                              output bit acc);
        bit fault;
        logic [5:0] w;
        acc   = hv && model_ready();
        fault = (er != 0) && (ms >= 1) && (ms <= 4);
        mpush = 0;
        if (fault) begin
            ms = 5; merr = 1; mq.delete(); acc = 0;
        end else begin
            case (ms)
                0: if (st) model_enter_init();
                1: begin ileft--; if (ileft == 0) ms = 2; end
                2: if (idl) ms = 3;
                3: begin
                    if (pz) ms = 4;
                    else if (mq.size() > 0) begin
                        w = mq.pop_front();
                        mpush = 1; mdata = w;
                        if (w[5]) mvc1 = (mvc1 < 255) ? mvc1 + 1 : 255;
                        else      mvc0 = (mvc0 < 255) ? mvc0 + 1 : 255;
                    end
                end
                4: if (!pz) ms = 3;
                5: if (st && er == 0) model_enter_init();
                default: ;
            endcase
            if (acc) mq.push_back(hd);
        end
    endtask

    task automatic check_all(input string name);
        logic [28:0] act, exp;
        act = {tx_state, push_main, data_in, init, host_ready, tx_error,
               afMF, aeMF, afVC, aeVC, afDF, aeDF};
        exp = {3'(ms), mpush, mdata, ms == 1, model_ready(), merr, mcfg ? THR : 16'h0};
        chk(name, 64'(act), 64'(exp));
`ifdef TX_STATS_EN
        chk({name, "_stats"}, {48'h0, words_vc0, words_vc1}, {48'h0, 8'(mvc0), 8'(mvc1)});
`endif
    endtask

    task automatic cycle(input bit st, input bit hv, input logic [5:0] hd,
                         input bit pz, input bit idl, input logic [4:0] er,
                         output bit acc);
        start = st; host_valid = hv; host_data = hd; pause = pz; idle = idl; error = er;
        model_edge(st, hv, hd, pz, idl, er, acc);
        @(posedge clk); #1;
        check_all("cycle");
    endtask

    typedef struct {
        bit st; bit hv; logic [5:0] hd; bit idl;
        logic [2:0] es; bit ep; logic [5:0] ed; bit ei; bit er;
    } vec_t;

    vec_t       tbl[10];
    logic [5:0] pw[6];
    bit         acc;
    int         wi, pcnt;

    initial begin
        tbl[0] = '{1, 0, 6'h00, 0, 3'd1, 0, 6'h00, 1, 1};
        tbl[1] = '{0, 0, 6'h00, 0, 3'd1, 0, 6'h00, 1, 1};
        tbl[2] = '{0, 0, 6'h00, 0, 3'd2, 0, 6'h00, 0, 1};
        tbl[3] = '{0, 0, 6'h00, 0, 3'd2, 0, 6'h00, 0, 1};
        tbl[4] = '{0, 0, 6'h00, 1, 3'd3, 0, 6'h00, 0, 1};
        tbl[5] = '{0, 1, 6'h21, 1, 3'd3, 0, 6'h00, 0, 1};
        tbl[6] = '{0, 1, 6'h12, 1, 3'd3, 1, 6'h21, 0, 1};
        tbl[7] = '{0, 1, 6'h3F, 1, 3'd3, 1, 6'h12, 0, 1};
        tbl[8] = '{0, 0, 6'h00, 1, 3'd3, 1, 6'h3F, 0, 1};
        tbl[9] = '{0, 0, 6'h00, 1, 3'd3, 0, 6'h3F, 0, 1};
        pw = '{6'h01, 6'h22, 6'h13, 6'h34, 6'h05, 6'h26};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset_L = 1'b1;

        // Init sequence and a three-word stream
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].st, tbl[i].hv, tbl[i].hd, 0, tbl[i].idl, 5'd0, acc);
            chk("tbl", {35'h0, tx_state, push_main, data_in, init, host_ready},
                {35'h0, tbl[i].es, tbl[i].ep, tbl[i].ed, tbl[i].ei, tbl[i].er});
        end
        chk("thresholds", {48'h0, afMF, aeMF, afVC, aeVC, afDF, aeDF}, {48'h0, THR});

        // Pause for 5 cycles while the host offers 6 words
        wi = 0; pcnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, wi < 6, pw[wi % 6], 1, 1, 5'd0, acc);
            if (acc) wi++;
            if (push_main) pcnt++;
        end
        chk("pause_nopush", 64'(pcnt), 64'd0);
        chk("pause_accepts", 64'(wi), 64'd4);
        chk("pause_ready", 64'(host_ready), 64'd0);
        pcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, wi < 6, pw[wi % 6], 0, 1, 5'd0, acc);
            if (acc) wi++;
            if (push_main) pcnt++;
        end
        chk("pause_drain", 64'(pcnt), 64'd6);

        // Error in SEND with three words buffered
        for (int i = 0; i < 3; i++) cycle(0, 1, pw[i], 1, 1, 5'd0, acc);
        cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        chk("pre_err_state", 64'(tx_state), 64'd3);
        cycle(0, 1, 6'h15, 0, 1, 5'b00100, acc);
        chk("err_push", 64'(push_main), 64'd0);
        chk("err_flag", 64'(tx_error), 64'd1);
        chk("err_state", 64'(tx_state), 64'd5);
        cycle(1, 0, 6'h00, 0, 1, 5'd0, acc);
        chk("err_restart", {62'h0, tx_state == 3'd1, tx_error}, 64'd3);
        pcnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
            if (push_main) pcnt++;
        end
        chk("err_flushed", 64'(pcnt), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) cycle(0, 1, 6'h2A, 0, 1, 5'd0, acc);
        chk("pre_rst_push", 64'(push_main), 64'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("rst_async_push", 64'(push_main), 64'd0);
        model_reset();
        check_all("rst_async");
        @(posedge clk); #1;
        check_all("rst_hold");
        reset_L = 1'b1;
        cycle(1, 0, 6'h00, 0, 0, 5'd0, acc);
        cycle(0, 1, 6'h07, 0, 0, 5'd0, acc);
        cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        chk("restart_push", {57'h0, push_main, data_in}, {57'h0, 1'b1, 6'h07});

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) == 0, $urandom % 2, 6'($urandom), ($urandom % 10) < 3,
                  $urandom % 2, (($urandom % 50) == 0) ? 5'($urandom_range(1, 31)) : 5'd0, acc);
        end

`ifdef TX_STATS_EN
        // Per-VC counters with saturation
        reset_L = 1'b0; model_reset();
        @(posedge clk); #1;
        reset_L = 1'b1;
        cycle(1, 0, 6'h00, 0, 0, 5'd0, acc);
        for (int i = 0; i < 3; i++) cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        for (int i = 0; i < 303; i++) cycle(0, 1, (i < 3) ? 6'h05 : 6'h2C, 0, 1, 5'd0, acc);
        for (int i = 0; i < 6; i++) cycle(0, 0, 6'h00, 0, 1, 5'd0, acc);
        chk("stats_vc0", 64'(words_vc0), 64'd3);
        chk("stats_vc1", 64'(words_vc1), 64'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
